// File: rtl/display_controller.sv
// display_controller: 640x480@60 VGA raster timing generator.
// It divides the system clock down to the pixel rate, runs the hCount/vCount
// raster counters and decodes sync and visible-window signals from them.
// It also issues a per-frame tick and a slower move tick that steps the game logic.
module display_controller #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515,
  parameter int unsigned MOVE_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_tick,
  output logic        move_tick,
  output logic [15:0] frame_cnt
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MOV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [MOV_W-1:0] MOV_LAST = MOV_W'(MOVE_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       HS_END   = 10'(H_SYNC);
  localparam logic [9:0]       VS_END   = 10'(V_SYNC);
  localparam logic [9:0]       HA_START = 10'(H_ACT_START);
  localparam logic [9:0]       HA_END   = 10'(H_ACT_END);
  localparam logic [9:0]       VA_START = 10'(V_ACT_START);
  localparam logic [9:0]       VA_END   = 10'(V_ACT_END);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             ft_q, ft_d;
  logic             mt_q, mt_d;
  logic [15:0]      fc_q, fc_d;
  logic [MOV_W-1:0] md_q, md_d;

  logic pix_adv;
  logic line_end;
  logic frame_end;

  assign pix_adv   = (div_q == DIV_LAST);
  assign line_end  = (h_q == H_LAST);
  assign frame_end = pix_adv && line_end && (v_q == V_LAST);

  // Gated with rst so pix_en stays low while reset is held, even with CLK_DIV=1
  assign pix_en = pix_adv & rst;

  // Next-state logic: pixel divider, raster counters, frame and move dividers
  always_comb begin
    div_d = pix_adv ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_adv) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    ft_d = frame_end;
    mt_d = frame_end && (md_q == MOV_LAST);
    fc_d = frame_end ? fc_q + 16'd1 : fc_q;
    md_d = md_q;
    if (frame_end) begin
      md_d = (md_q == MOV_LAST) ? '0 : md_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      ft_q  <= 1'b0;
      mt_q  <= 1'b0;
      fc_q  <= '0;
      md_q  <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      ft_q  <= ft_d;
      mt_q  <= mt_d;
      fc_q  <= fc_d;
      md_q  <= md_d;
    end
  end

  // Sync and visible-window decode straight from the registered counters
  always_comb begin
    hSync  = (h_q >= HS_END);
    vSync  = (v_q >= VS_END);
    bright = (h_q >= HA_START) && (h_q < HA_END) &&
             (v_q >= VA_START) && (v_q < VA_END);
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign frame_tick = ft_q;
  assign move_tick  = mt_q;
  assign frame_cnt  = fc_q;

endmodule

// File: tb/tb_display_controller.sv
// tb_display_controller: scoreboard bench for display_controller using a
// shrunken raster so that several frames fit in a short run.
module tb_display_controller;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned H_TOTAL     = 20;
  localparam int unsigned H_SYNC      = 3;
  localparam int unsigned H_ACT_START = 5;
  localparam int unsigned H_ACT_END   = 17;
  localparam int unsigned V_TOTAL     = 8;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_ACT_START = 3;
  localparam int unsigned V_ACT_END   = 7;
  localparam int unsigned MOVE_DIV    = 3;
  localparam int unsigned FRAME_CLKS  = CLK_DIV * H_TOTAL * V_TOTAL;

  typedef struct {
    logic        pix_en;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic        ft;
    logic        mt;
    logic [15:0] fc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic        frame_tick;
  logic        move_tick;
  logic [15:0] frame_cnt;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned n_cyc;
  exp_t        sb[$];

  display_controller #(
    .CLK_DIV    (CLK_DIV),
    .H_TOTAL    (H_TOTAL),
    .H_SYNC     (H_SYNC),
    .H_ACT_START(H_ACT_START),
    .H_ACT_END  (H_ACT_END),
    .V_TOTAL    (V_TOTAL),
    .V_SYNC     (V_SYNC),
    .V_ACT_START(V_ACT_START),
    .V_ACT_END  (V_ACT_END),
    .MOVE_DIV   (MOVE_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .hCount    (hCount),
    .vCount    (vCount),
    .hSync     (hSync),
    .vSync     (vSync),
    .bright    (bright),
    .frame_tick(frame_tick),
    .move_tick (move_tick),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs t clock edges after reset release, from raster arithmetic
  function automatic exp_t model(input int unsigned t);
    exp_t        e;
    int unsigned p, h, v, frames;
    p      = t / CLK_DIV;
    h      = p % H_TOTAL;
    v      = (p / H_TOTAL) % V_TOTAL;
    frames = t / FRAME_CLKS;
    e.pix_en = ((t % CLK_DIV) == CLK_DIV - 1);
    e.h      = 10'(h);
    e.v      = 10'(v);
    e.hs     = (h >= H_SYNC);
    e.vs     = (v >= V_SYNC);
    e.br     = (h >= H_ACT_START) && (h < H_ACT_END) &&
               (v >= V_ACT_START) && (v < V_ACT_END);
    e.ft     = (t > 0) && ((t % FRAME_CLKS) == 0);
    e.mt     = e.ft && ((frames % MOVE_DIV) == 0);
    e.fc     = 16'(frames % 65536);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.pix_en = 1'b0;
    e.h      = '0;
    e.v      = '0;
    e.hs     = 1'b0;
    e.vs     = 1'b0;
    e.br     = 1'b0;
    e.ft     = 1'b0;
    e.mt     = 1'b0;
    e.fc     = '0;
    return e;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s sample=%0d actual=%0d required=%0d", nm, n_cyc, act, req);
    end
  endtask

  // Monitor: one expected entry is consumed per sampled cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pix_en",     32'(pix_en),     32'(e.pix_en));
      chk("hCount",     32'(hCount),     32'(e.h));
      chk("vCount",     32'(vCount),     32'(e.v));
      chk("hSync",      32'(hSync),      32'(e.hs));
      chk("vSync",      32'(vSync),      32'(e.vs));
      chk("bright",     32'(bright),     32'(e.br));
      chk("frame_tick", 32'(frame_tick), 32'(e.ft));
      chk("move_tick",  32'(move_tick),  32'(e.mt));
      chk("frame_cnt",  32'(frame_cnt),  32'(e.fc));
      n_cyc++;
    end
  end

  task automatic hold_reset(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.push_back(reset_exp());
    end
  endtask

  task automatic run_from_release(input int unsigned cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.push_back(model(0));
    for (int unsigned t = 1; t < cycles; t++) begin
      @(posedge clk);
      #1;
      sb.push_back(model(t));
    end
  endtask

  initial begin
    int unsigned off;
    n_cmp = 0;
    n_bad = 0;
    n_cyc = 0;
    rst   = 1'b0;
    hold_reset(3);
    off = $urandom_range(3 * FRAME_CLKS / 4, FRAME_CLKS / 4);
    run_from_release(7 * FRAME_CLKS + off);
    // Reset asserted mid-clock: outputs must clear before the next edge
    hold_reset(1 + $urandom_range(4, 0));
    off = $urandom_range(40, 2);
    run_from_release(2 * FRAME_CLKS + off);
    hold_reset(2);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_controller.md
Name: display_controller

Overview:
- Generates 640x480@60 VGA raster timing: hCount, vCount, bright, hSync and vSync.
- Drives the pixel-side interface of block_controller (inputs hCount, vCount, bright).
- Also produces the frame-rate move tick that clocks the game logic.
- Replaces the bench-driven hc/vc/move_clk stimulus with the real initiator of that interface.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal range >= 1.
- H_TOTAL, 800, pixels per line (hCount range 0..H_TOTAL-1).
- H_SYNC, 96, hSync low while hCount < H_SYNC.
- H_ACT_START, 144, first visible hCount.
- H_ACT_END, 784, first non-visible hCount after the active region.
- V_TOTAL, 525, lines per frame (vCount range 0..V_TOTAL-1).
- V_SYNC, 2, vSync low while vCount < V_SYNC.
- V_ACT_START, 35, first visible vCount.
- V_ACT_END, 515, first non-visible vCount after the active region.
- MOVE_DIV, 1, frames per move_tick pulse; legal range >= 1.

Ports:
- clk, input, 1: system clock (100 MHz). The block has one clock.
- rst, input, 1: reset, asynchronous, active-low (0 = reset).
- pix_en, output, 1: one-clk pulse marking the pixel advance.
- hCount, output, 10: horizontal pixel counter.
- vCount, output, 10: vertical line counter.
- hSync, output, 1: horizontal sync, active low.
- vSync, output, 1: vertical sync, active low.
- bright, output, 1: high inside the visible 640x480 window.
- frame_tick, output, 1: one-clk pulse at each frame wrap.
- move_tick, output, 1: one-clk pulse every MOVE_DIV frames; the game-logic step.
- frame_cnt, output, 16: count of completed frames since reset.

Behaviour:
- Reset (rst=0): takes effect asynchronously, with no clock edge required.
  - Internal div_cnt=0; hCount=0; vCount=0; pix_en=0; frame_tick=0; move_tick=0; frame_cnt=0.
  - hSync=0, vSync=0 and bright=0, consistent with the decode at (0,0).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is high for exactly the clk cycle in which div_cnt==CLK_DIV-1.
  - CLK_DIV=1: pix_en is high every cycle after reset release.
  - After release with CLK_DIV=4, pix_en is high in cycles 3, 7, 11, ... (cycle 0 = first edge after release).
- Counters change only on a clk edge that ends a pix_en cycle:
  - hCount increments.
  - At hCount==H_TOTAL-1: hCount goes to 0 and vCount increments.
  - At (H_TOTAL-1, V_TOTAL-1): both counters go to 0.
- Decode is combinational from the registered counters, so it has the same timing as the counters (0 latency):
  - hSync = (hCount >= H_SYNC).
  - vSync = (vCount >= V_SYNC).
  - bright = H_ACT_START <= hCount < H_ACT_END AND V_ACT_START <= vCount < V_ACT_END.
- frame_tick: registered; high for exactly the first clk cycle in which the counters are (0,0) due to a wrap.
  - Reset release does not produce a frame_tick.
- frame_cnt: increments by 1 on each frame_tick; wraps 65535 -> 0 silently.
- move_tick: internal frame divider counts frame_ticks 0..MOVE_DIV-1.
  - move_tick coincides with the frame_tick that completes each group of MOVE_DIV frames (the MOVE_DIV-th, 2*MOVE_DIV-th, ...).
  - MOVE_DIV=1: move_tick == frame_tick.
- Simultaneous events: a line wrap and a frame wrap at (799,524) are a single event; vCount goes to 0, never to 525.
- Reset mid-frame:
  - All state clears immediately; no partial pulse appears.
  - After release the raster restarts at (0,0), the frame divider restarts at 0, and the first frame_tick arrives one full frame later.
- Out-of-range counter values are unreachable. The decode does not need to handle them, but the counters must never exceed TOTAL-1.

Test Plan:
1. Reset release, CLK_DIV=4 -> pix_en high in cycles 3, 7, 11; hCount reads 1 in cycle 4 and 2 in cycle 8; vCount=0; no frame_tick.
2. Line wrap at hCount=799 with pix_en -> next values (0, vCount+1); hSync=0 for hCount 0..95 and 1 at 96..799; vSync=0 only for vCount 0..1.
3. Full frame -> consecutive frame_ticks exactly 1,680,000 clks apart (800*525*4); bright counted over pix_en cycles = 307,200 per frame.
4. bright boundaries -> (143,35)=0, (144,35)=1, (783,514)=1, (784,514)=0, (144,34)=0, (144,515)=0.
5. MOVE_DIV=3, run 7 frames -> move_tick on frame_ticks 3 and 6 only; frame_cnt reads 7.
6. rst pulled low mid-clock at (400,300) with frame_cnt=5 -> all outputs at reset values before the next clk edge; after release, first frame_tick after 1,680,000 clks and frame_cnt then reads 1.
